// File: rtl/glb_dma_pkg.sv
// Shared types and constants for the DRAM<->GLB DMA controller.
package glb_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        BWD,
        DRAIN,
        DONE_PULSE
    } state_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

    localparam int CH_IFMAP  = 0;
    localparam int CH_FILTER = 1;
    localparam int CH_BIAS   = 2;
    localparam int CH_PSUM   = 3;

endpackage

// File: rtl/glb_dma_beat_counter.sv
// Loadable terminal-count beat counter; last_o flags the beat that completes the transfer.
module glb_dma_beat_counter #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] term_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] term_q, term_d;

    always_comb begin
        cnt_d  = cnt_q;
        term_d = term_q;
        if (load_i) begin
            cnt_d  = '0;
            term_d = term_i;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            term_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign cnt_o  = cnt_q;
    // Terminal count of zero never reaches a beat state, so the wrap of term_q-1 is harmless.
    assign last_o = (cnt_q == term_q - ONE);

endmodule

// File: rtl/glb_dma_controller.sv
// DRAM<->GLB DMA controller with valid/ready beats and a post-transfer drain period.
// Optional stall counter enabled by defining GLB_DMA_STALL_CNT_EN.
module glb_dma_controller
    import glb_dma_pkg::*;
#(
    parameter int ADDR_WIDTH   = 20,
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 2,
    parameter int DRAIN_CYCLES = 6,
    parameter int CNT_W        = 4
) (
    input  logic                  core_clk,
    input  logic                  core_reset,
    input  logic                  start,
    input  logic                  dir,
    input  logic [CH_W-1:0]       chan_sel,
    input  logic [ADDR_WIDTH-1:0] words_num,
    input  logic                  dram_valid,
    input  logic                  glb_wfull,
    input  logic                  glb_rempty,
    input  logic                  dram_ready,
    output logic                  read_from_DRAM,
    output logic [NUM_CH-1:0]     glb_winc,
    output logic                  read_from_GLB,
    output logic                  DRAM_w_en,
    output logic                  Direct_Back_Path,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] beat_cnt,
    output logic [NUM_CH-1:0]     transfer_done,
    output logic                  back_transfer_done,
    output logic [ADDR_WIDTH-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] DRN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRN_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic              dir_q, dir_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [CNT_W-1:0]  drn_q, drn_d;
    logic              accept, fwd_beat, bwd_beat, last_beat;
    logic [NUM_CH-1:0] chan_oh;

    assign accept   = (state_q == IDLE) && start;
    assign fwd_beat = (state_q == FWD) && dram_valid && !glb_wfull;
    assign bwd_beat = (state_q == BWD) && !glb_rempty && dram_ready;

    // Out-of-range channels decode to all-zero: beats still drain the source, nothing is written.
    always_comb begin
        chan_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            chan_oh[i] = (int'(chan_q) == i);
        end
    end

    glb_dma_beat_counter #(.W(ADDR_WIDTH)) u_beat_cnt (
        .clk    (core_clk),
        .rst    (core_reset),
        .load_i (accept),
        .term_i (words_num),
        .inc_i  (fwd_beat || bwd_beat),
        .clr_i  (state_q == DONE_PULSE),
        .cnt_o  (beat_cnt),
        .last_o (last_beat)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        chan_d  = chan_q;
        drn_d   = drn_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d  = dir;
                    chan_d = chan_sel;
                    if (words_num == '0)       state_d = DONE_PULSE;
                    else if (dir == DIR_BWD)   state_d = BWD;
                    else                       state_d = FWD;
                end
            end
            FWD:   if (fwd_beat && last_beat) state_d = DRAIN;
            BWD:   if (bwd_beat && last_beat) state_d = DRAIN;
            DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    drn_d   = '0;
                    state_d = DONE_PULSE;
                end else begin
                    drn_d = drn_q + DRN_ONE;
                end
            end
            DONE_PULSE: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or posedge core_reset) begin
        if (core_reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            chan_q  <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            chan_q  <= chan_d;
            drn_q   <= drn_d;
        end
    end

    assign read_from_DRAM     = fwd_beat;
    assign glb_winc           = fwd_beat ? chan_oh : '0;
    assign read_from_GLB      = bwd_beat;
    assign DRAM_w_en          = bwd_beat;
    assign Direct_Back_Path   = (dir_q == DIR_BWD) && ((state_q == BWD) || (state_q == DRAIN));
    assign busy               = (state_q != IDLE);
    assign transfer_done      = ((state_q == DONE_PULSE) && (dir_q == DIR_FWD)) ? chan_oh : '0;
    assign back_transfer_done = (state_q == DONE_PULSE) && (dir_q == DIR_BWD);

`ifdef GLB_DMA_STALL_CNT_EN
    logic [ADDR_WIDTH-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept)
            stall_d = '0;
        else if (((state_q == FWD) && !fwd_beat) || ((state_q == BWD) && !bwd_beat))
            stall_d = (stall_q == '1) ? stall_q : stall_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge core_clk or posedge core_reset) begin
        if (core_reset) stall_q <= '0;
        else            stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_glb_dma_controller.sv
// Scoreboard bench for glb_dma_controller: expected beat indices are queued at start and popped per strobe.
module tb_glb_dma_controller;

    localparam int AW = 20;
    localparam int NC = 4;
    localparam int CW = 2;
    localparam int DC = 6;
`ifdef GLB_DMA_STALL_CNT_EN
    localparam int EXP_STALL = 3;
`else
    localparam int EXP_STALL = 0;
`endif

    logic          core_clk = 1'b0;
    logic          core_reset;
    logic          start, dir, dram_valid, glb_wfull, glb_rempty, dram_ready;
    logic [CW-1:0] chan_sel;
    logic [AW-1:0] words_num;
    logic          read_from_DRAM, read_from_GLB, DRAM_w_en, Direct_Back_Path, busy, back_transfer_done;
    logic [NC-1:0] glb_winc, transfer_done;
    logic [AW-1:0] beat_cnt, stall_cycles;

    int vecs = 0;
    int errs = 0;
    int sbq[$];

    glb_dma_controller #(.ADDR_WIDTH(AW), .NUM_CH(NC), .CH_W(CW), .DRAIN_CYCLES(DC), .CNT_W(4)) dut (
        .core_clk(core_clk), .core_reset(core_reset), .start(start), .dir(dir),
        .chan_sel(chan_sel), .words_num(words_num), .dram_valid(dram_valid),
        .glb_wfull(glb_wfull), .glb_rempty(glb_rempty), .dram_ready(dram_ready),
        .read_from_DRAM(read_from_DRAM), .glb_winc(glb_winc), .read_from_GLB(read_from_GLB),
        .DRAM_w_en(DRAM_w_en), .Direct_Back_Path(Direct_Back_Path), .busy(busy),
        .beat_cnt(beat_cnt), .transfer_done(transfer_done),
        .back_transfer_done(back_transfer_done), .stall_cycles(stall_cycles)
    );

    always #5 core_clk = ~core_clk;

    task automatic start_xfer(input logic d, input logic [CW-1:0] ch, input logic [AW-1:0] n);
        @(negedge core_clk);
        start = 1'b1; dir = d; chan_sel = ch; words_num = n;
        sbq.delete();
        for (int k = 0; k < int'(n); k++) sbq.push_back(k);
        @(posedge core_clk);
        @(negedge core_clk);
        start = 1'b0;
    endtask

    function automatic logic all_quiet();
        return {read_from_DRAM, glb_winc, read_from_GLB, DRAM_w_en, Direct_Back_Path, busy,
                beat_cnt, transfer_done, back_transfer_done, stall_cycles} == '0;
    endfunction

    task automatic test_reset();
        core_reset = 1'b1;
        start = 0; dir = 0; chan_sel = '0; words_num = '0;
        dram_valid = 0; glb_wfull = 0; glb_rempty = 1; dram_ready = 0;
        repeat (2) @(negedge core_clk);
        #1 vecs++;
        if (!all_quiet()) begin errs++; $display("FAIL reset_outputs busy=%b beat_cnt=%0d req all zero", busy, beat_cnt); end
        core_reset = 1'b0;
        @(negedge core_clk);
        #1 vecs++;
        if (!all_quiet()) begin errs++; $display("FAIL post_reset_idle busy=%b req 0", busy); end
    endtask

    // Forward transfer monitor; wf_mode 1 toggles glb_wfull every other cycle.
    task automatic run_fwd(input string nm, input logic [CW-1:0] ch, input int n,
                           input logic [NC-1:0] exp_oh, input bit wf_mode, input bit consec);
        int e, last, nb, bc_last;
        bit seen;
        last = -100; nb = 0; bc_last = -1; seen = 0;
        dram_valid = 1; glb_wfull = 0;
        start_xfer(1'b0, ch, n[AW-1:0]);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (wf_mode) glb_wfull = (i % 2 == 1);
            #1;
            if (read_from_DRAM || glb_winc != 0) begin
                vecs++; nb++; last = i; bc_last = int'(beat_cnt);
                if (sbq.size() == 0) begin
                    errs++; $display("FAIL %s_extra_beat cyc=%0d winc=%b req no beat", nm, i, glb_winc);
                end else begin
                    e = sbq.pop_front();
                    if (glb_winc !== exp_oh || read_from_DRAM !== 1'b1 || glb_wfull !== 1'b0 ||
                        int'(beat_cnt) !== e || (consec && i !== e)) begin
                        errs++;
                        $display("FAIL %s_beat cyc=%0d winc=%b cnt=%0d wfull=%b req winc=%b cnt=%0d",
                                 nm, i, glb_winc, beat_cnt, glb_wfull, exp_oh, e);
                    end
                end
            end
            if (transfer_done !== '0) begin
                vecs++; seen = 1;
                if (transfer_done !== exp_oh || i - last !== DC + 1) begin
                    errs++;
                    $display("FAIL %s_done got=%b gap=%0d req=%b gap=%0d", nm, transfer_done, i - last, exp_oh, DC + 1);
                end
            end
            @(negedge core_clk);
        end
        glb_wfull = 0; dram_valid = 0;
        vecs++;
        if (!seen || sbq.size() != 0 || nb != n || bc_last != n - 1) begin
            errs++;
            $display("FAIL %s_complete done_seen=%0d beats=%0d last_cnt=%0d req beats=%0d last_cnt=%0d",
                     nm, seen, nb, bc_last, n, n - 1);
        end
        #1 vecs++;
        if (busy !== 1'b0 || beat_cnt !== '0) begin
            errs++; $display("FAIL %s_idle busy=%b cnt=%0d req 0 0", nm, busy, beat_cnt);
        end
    endtask

    task automatic test_fwd_basic();
        run_fwd("fwd_basic", 2'd1, 8, 4'b0010, 1'b0, 1'b1);
    endtask

    task automatic test_fwd_wfull();
        run_fwd("fwd_wfull", 2'd2, 5, 4'b0100, 1'b1, 1'b0);
    endtask

    task automatic test_bwd();
        int e, last, nb;
        bit seen;
        last = -100; nb = 0; seen = 0;
        dram_valid = 0; glb_rempty = 0;
        start_xfer(1'b1, 2'd0, 4);
        for (int i = 0; i < 40 && !seen; i++) begin
            dram_ready = !(i >= 2 && i <= 4);
            #1;
            if (read_from_GLB || DRAM_w_en) begin
                vecs++; nb++; last = i;
                if (sbq.size() == 0) begin
                    errs++; $display("FAIL bwd_extra_beat cyc=%0d req no beat", i);
                end else begin
                    e = sbq.pop_front();
                    if (read_from_GLB !== 1'b1 || DRAM_w_en !== 1'b1 || dram_ready !== 1'b1 || int'(beat_cnt) !== e) begin
                        errs++;
                        $display("FAIL bwd_beat cyc=%0d rg=%b dw=%b cnt=%0d req 1 1 cnt=%0d", i, read_from_GLB, DRAM_w_en, beat_cnt, e);
                    end
                end
            end
            if (back_transfer_done) begin
                vecs++; seen = 1;
                if (i - last !== DC + 1) begin
                    errs++; $display("FAIL bwd_done_gap got=%0d req=%0d", i - last, DC + 1);
                end
            end else begin
                vecs++;
                if (Direct_Back_Path !== 1'b1 || transfer_done !== '0 || read_from_DRAM !== 1'b0) begin
                    errs++;
                    $display("FAIL bwd_path cyc=%0d dbp=%b td=%b req dbp=1 td=0", i, Direct_Back_Path, transfer_done);
                end
            end
            @(negedge core_clk);
        end
        glb_rempty = 1; dram_ready = 0;
        vecs++;
        if (!seen || nb != 4 || sbq.size() != 0) begin
            errs++; $display("FAIL bwd_complete done_seen=%0d beats=%0d req 1 4", seen, nb);
        end
        #1 vecs++;
        if (busy !== 1'b0 || Direct_Back_Path !== 1'b0) begin
            errs++; $display("FAIL bwd_idle busy=%b dbp=%b req 0 0", busy, Direct_Back_Path);
        end
    endtask

    task automatic test_zero_len();
        dram_valid = 1;
        start_xfer(1'b0, 2'd3, 0);
        #1 vecs++;
        if (transfer_done !== 4'b1000 || read_from_DRAM !== 1'b0 || glb_winc !== '0) begin
            errs++; $display("FAIL zero_len_done td=%b rd=%b winc=%b req 1000 0 0000", transfer_done, read_from_DRAM, glb_winc);
        end
        @(negedge core_clk);
        #1 vecs++;
        if (busy !== 1'b0 || transfer_done !== '0 || read_from_DRAM !== 1'b0) begin
            errs++; $display("FAIL zero_len_idle busy=%b td=%b req 0 0", busy, transfer_done);
        end
        dram_valid = 0;
    endtask

    task automatic test_reset_mid();
        bit bad;
        bad = 0;
        dram_valid = 1; glb_wfull = 0;
        start_xfer(1'b0, 2'd0, 10);
        for (int i = 0; i < 3; i++) begin
            #1 vecs++;
            if (read_from_DRAM !== 1'b1 || int'(beat_cnt) !== i) begin
                errs++; $display("FAIL rst_mid_pre cyc=%0d rd=%b cnt=%0d req 1 %0d", i, read_from_DRAM, beat_cnt, i);
            end
            @(negedge core_clk);
        end
        core_reset = 1'b1;
        #1 vecs++;
        if (!all_quiet()) begin
            errs++; $display("FAIL rst_mid_outputs busy=%b cnt=%0d winc=%b req all zero", busy, beat_cnt, glb_winc);
        end
        repeat (2) @(negedge core_clk);
        core_reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1 if (transfer_done !== '0 || busy !== 1'b0 || read_from_DRAM !== 1'b0) bad = 1;
            @(negedge core_clk);
        end
        vecs++;
        if (bad) begin errs++; $display("FAIL rst_mid_no_done activity after abort req none"); end
        run_fwd("rst_mid_restart", 2'd0, 3, 4'b0001, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        bit seen;
        seen = 0;
        glb_wfull = 0; dram_valid = 1;
        start_xfer(1'b0, 2'd3, 6);
        for (int i = 0; i < 40 && !seen; i++) begin
            dram_valid = !(i == 1 || i == 3 || i == 5);
            #1;
            if (transfer_done !== '0) begin
                vecs++; seen = 1;
                if (int'(stall_cycles) !== EXP_STALL || transfer_done !== 4'b1000) begin
                    errs++; $display("FAIL stall_count got=%0d td=%b req=%0d td=1000", stall_cycles, transfer_done, EXP_STALL);
                end
            end
            @(negedge core_clk);
        end
        dram_valid = 0;
        vecs++;
        if (!seen) begin errs++; $display("FAIL stall_done timeout req done pulse"); end
    endtask

    initial begin
        test_reset();
        test_fwd_basic();
        test_fwd_wfull();
        test_bwd();
        test_zero_len();
        test_reset_mid();
        test_stall();
        repeat (2) @(negedge core_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
